// File: rtl/alu_cmd_issue.sv
// Command FIFO and issuer feeding alu_seq, with result chaining (one bubble after a back-to-back issue).
// Optional macro ALU_ISSUE_COUNT_EN adds an 8-bit wrapping issue counter output.
module alu_cmd_issue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_a,
    input  logic [3:0]               cmd_b,
    input  logic [2:0]               cmd_op,
    input  logic                     cmd_chain,
    input  logic [3:0]               alu_result,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [2:0]               alu_op,
    output logic                     alu_issue,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
`ifdef ALU_ISSUE_COUNT_EN
    ,
    output logic [7:0]               issue_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 12;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] ISSUE      = 2'd1;
    localparam logic [1:0] CHAIN_WAIT = 2'd2;

    logic [CW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [AW:0]   count_nxt;
    logic          full;
    logic          push;
    logic          pop;
    logic          a_from_result;

    logic [CW-1:0] head;
    logic [3:0]    head_a;
    logic [3:0]    head_b;
    logic [2:0]    head_op;
    logic          head_chain;

    always_comb begin
        head       = mem[rd_ptr];
        head_a     = head[11:8];
        head_b     = head[7:4];
        head_op    = head[3:1];
        head_chain = head[0];
    end

    always_comb begin
        full      = (fifo_count == FULL_COUNT);
        cmd_ready = !rst && !full;
        push      = cmd_valid && cmd_ready;
        busy      = (fifo_count != '0) || (state != IDLE);
    end

    // alu_issue being high means the previous edge issued, so a chained head must wait one cycle.
    always_comb begin
        pop           = 1'b0;
        a_from_result = 1'b0;
        state_nxt     = state;
        case (state)
            IDLE: begin
                if (push) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (fifo_count != '0) begin
                    if (head_chain && alu_issue) begin
                        state_nxt = CHAIN_WAIT;
                    end else begin
                        pop           = 1'b1;
                        a_from_result = head_chain;
                    end
                end else begin
                    state_nxt = push ? ISSUE : IDLE;
                end
            end
            CHAIN_WAIT: begin
                pop           = 1'b1;
                a_from_result = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        count_nxt = fifo_count + (AW + 1)'(push) - (AW + 1)'(pop);
        if (pop) state_nxt = (count_nxt == '0) ? IDLE : ISSUE;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op, cmd_chain};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_issue  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                alu_a  <= a_from_result ? alu_result : head_a;
                alu_b  <= head_b;
                alu_op <= head_op;
            end
            alu_issue  <= pop;
            fifo_count <= count_nxt;
            state      <= state_nxt;
        end
    end

`ifdef ALU_ISSUE_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)      issue_count <= '0;
        else if (pop) issue_count <= issue_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Self-checking bench for alu_cmd_issue: queue-based reference model plus directed literal checks.
module tb_alu_cmd_issue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic [2:0] cmd_op = '0;
    logic       cmd_chain = 1'b0;
    logic [3:0] alu_result;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic       alu_issue;
    logic [2:0] fifo_count;
    logic       busy;
`ifdef ALU_ISSUE_COUNT_EN
    logic [7:0] issue_count;
`endif

    int checks = 0;
    int errors = 0;
    bit started = 0;

    always #5 clk = ~clk;

    alu_cmd_issue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
        .alu_result(alu_result), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_issue(alu_issue), .fifo_count(fifo_count), .busy(busy)
`ifdef ALU_ISSUE_COUNT_EN
        , .issue_count(issue_count)
`endif
    );

    function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return a;
            default: return b;
        endcase
    endfunction

    // Stand-in for alu_seq: registered result of whatever the issuer drives.
    always @(posedge clk) begin
        if (rst) alu_result <= '0;
        else     alu_result <= alu_fn(alu_a, alu_b, alu_op);
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending commands; the head issues unless it is chained
    // and the previous edge already issued.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic       chain;
    } cmd_t;

    cmd_t        q[$];
    logic [3:0]  m_a, m_b, m_res;
    logic [2:0]  m_op;
    logic        m_issue;
    int unsigned m_icnt;

    always @(posedge clk) begin
        bit         psh;
        logic [3:0] next_res;
        cmd_t       c;
        if (rst) begin
            q.delete();
            m_a = '0; m_b = '0; m_op = '0; m_res = '0;
            m_issue = 1'b0;
            m_icnt = 0;
        end else begin
            next_res = alu_fn(m_a, m_b, m_op);
            psh = cmd_valid && (q.size() < DEPTH);
            if (q.size() > 0 && !(q[0].chain && m_issue)) begin
                c = q.pop_front();
                m_a = c.chain ? m_res : c.a;
                m_b = c.b;
                m_op = c.op;
                m_issue = 1'b1;
                m_icnt++;
            end else begin
                m_issue = 1'b0;
            end
            if (psh) q.push_back('{cmd_a, cmd_b, cmd_op, cmd_chain});
            m_res = next_res;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cmd_ready", {7'd0, cmd_ready}, {7'd0, (!rst && q.size() < DEPTH)});
            check("fifo_count", {5'd0, fifo_count}, 8'(q.size()));
            check("alu_issue", {7'd0, alu_issue}, {7'd0, m_issue});
            check("alu_a", {4'd0, alu_a}, {4'd0, m_a});
            check("alu_b", {4'd0, alu_b}, {4'd0, m_b});
            check("alu_op", {5'd0, alu_op}, {5'd0, m_op});
            check("busy", {7'd0, busy}, {7'd0, (q.size() != 0)});
`ifdef ALU_ISSUE_COUNT_EN
            check("issue_count", issue_count, m_icnt[7:0]);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic ch);
        cmd_valid = v; cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = ch;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        bit saw_full;

        // Reset state
        rst = 1'b1;
        step();
        started = 1;
        step();
        check("rst_count", {5'd0, fifo_count}, 8'd0);
        check("rst_ready", {7'd0, cmd_ready}, 8'd0);
        check("rst_alu_a", {4'd0, alu_a}, 8'd0);
        check("rst_issue", {7'd0, alu_issue}, 8'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {7'd0, cmd_ready}, 8'd1);

        // Single command: issued one edge after the push edge
        drive(1, 4'd5, 4'd3, 3'd0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        check("single_latency", {7'd0, alu_issue}, 8'd0);
        step();
        check("single_issue", {7'd0, alu_issue}, 8'd1);
        check("single_a", {4'd0, alu_a}, 8'd5);
        check("single_b", {4'd0, alu_b}, 8'd3);
        check("single_op", {5'd0, alu_op}, 8'd0);
        step();
        check("single_done", {7'd0, alu_issue}, 8'd0);
        check("single_busy", {7'd0, busy}, 8'd0);

        // Four back-to-back unchained commands
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'(i + 1), 4'(i + 8), 3'(i), 0);
            step();
            if (i > 0) begin
                check("b2b_issue", {7'd0, alu_issue}, 8'd1);
                check("b2b_a", {4'd0, alu_a}, 8'(i));
            end
        end
        drive(0, 0, 0, 0, 0);
        step();
        check("b2b_last_a", {4'd0, alu_a}, 8'd4);
        check("b2b_last_issue", {7'd0, alu_issue}, 8'd1);
        step();
        check("b2b_idle", {7'd0, alu_issue}, 8'd0);

        // Chain: 4+3, then chained +1 after one bubble
        drive(1, 4'd4, 4'd3, 3'd0, 0);
        step();
        drive(1, 4'd15, 4'd1, 3'd0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        check("chain_first_a", {4'd0, alu_a}, 8'd4);
        step();
        check("chain_bubble", {7'd0, alu_issue}, 8'd0);
        step();
        check("chain_issue", {7'd0, alu_issue}, 8'd1);
        check("chain_a", {4'd0, alu_a}, 8'd7);
        check("chain_b", {4'd0, alu_b}, 8'd1);
        step();
        check("chain_result", {4'd0, alu_result}, 8'd8);

        // All-chain backlog fills the FIFO
        do_reset();
        saw_full = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1, 4'($urandom), 4'($urandom), 3'($urandom), 1);
            step();
            if (fifo_count == 3'd4 && cmd_ready == 1'b0) saw_full = 1;
        end
        drive(0, 0, 0, 0, 0);
        check("fill_full", {7'd0, saw_full}, 8'd1);
        for (int i = 0; i < 12; i++) step();

        // Reset while three commands are queued and a chain bubble is pending
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'(i), 4'(i + 2), 3'd0, 1);
            step();
        end
        check("pre_rst_count", {5'd0, fifo_count}, 8'd3);
        check("pre_rst_bubble", {7'd0, alu_issue}, 8'd0);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_count", {5'd0, fifo_count}, 8'd0);
        check("mid_rst_a", {4'd0, alu_a}, 8'd0);
        check("mid_rst_b", {4'd0, alu_b}, 8'd0);
        check("mid_rst_op", {5'd0, alu_op}, 8'd0);
        check("mid_rst_busy", {7'd0, busy}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_quiet", {7'd0, alu_issue}, 8'd0);
        end

`ifdef ALU_ISSUE_COUNT_EN
        do_reset();
        for (int i = 0; i < 257; i++) begin
            drive(1, 4'($urandom), 4'($urandom), 3'($urandom), 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        step();
        step();
        check("issue_count_wrap", issue_count, 8'd1);
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 3'($urandom),
                  $urandom_range(0, 2) == 0);
            step();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issue.md
Name: alu_cmd_issue

Overview:
Upstream command stage for alu_seq. Buffers operand/opcode commands in a small FIFO behind a valid/ready handshake and issues one command per cycle onto the ALU input bus (a, b, op). Supports result chaining: a chained command takes the ALU's previous result as operand A, inserting the one bubble that the registered ALU output requires.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of two, minimum 2
CW, 12, command word width (a 4 + b 4 + op 3 + chain 1); fixed, not for override

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  producer has a command on cmd_*
cmd_ready  output  1  FIFO can accept; push occurs when cmd_valid && cmd_ready at posedge
cmd_a  input  4  operand A, ignored when cmd_chain=1
cmd_b  input  4  operand B
cmd_op  input  3  ALU opcode, passed through unmodified
cmd_chain  input  1  1 = use last alu_result as A
alu_result  input  4  alu_seq registered result
alu_a  output  4  registered operand A to alu_seq
alu_b  output  4  registered operand B to alu_seq
alu_op  output  3  registered opcode to alu_seq
alu_issue  output  1  one-cycle strobe: alu_* changed to a new command at this edge
fifo_count  output  $clog2(DEPTH)+1  entries currently held
busy  output  1  fifo_count != 0 or state != IDLE

Behaviour:
- Reset (sync, rst=1 at posedge): alu_a=0, alu_b=0, alu_op=0, alu_issue=0, fifo_count=0, FIFO pointers=0, state=IDLE, cmd_ready=0 while rst high, 1 on the first cycle after. Reset mid-operation discards all queued commands and any pending chain.
- cmd_ready = !full, derived from current occupancy only. A push while full is not accepted, even with a pop in the same cycle. Simultaneous push+pop when not full: count unchanged.
- FIFO latency: a command pushed at edge N is issued no earlier than edge N+1.
- alu_a/b/op hold their last values whenever no issue occurs. The ALU therefore keeps recomputing the same result, and alu_result stays stable between issues.
- States:
  - IDLE: FIFO empty, alu_issue=0. Goes to ISSUE when count becomes non-zero.
  - ISSUE: each edge with head present, the issuer pops the head and drives alu_b=head.b and alu_op=head.op; alu_issue=1.
    - If head.chain=0: alu_a=head.a.
    - If head.chain=1 and the previous edge was also an issue edge: no pop, alu_issue=0, go to CHAIN_WAIT (bubble).
    - If head.chain=1 and the previous edge was not an issue edge: alu_a=alu_result sampled at this edge, pop.
    - If the FIFO is empty after the pop, go to IDLE.
  - CHAIN_WAIT: exactly one cycle. At the next edge, pop the head with alu_a=alu_result (now reflecting the prior command), alu_issue=1, and return to ISSUE or IDLE.
- Chain with no prior issue since reset uses alu_result as-is (0 after ALU reset).
- Throughput: 1 command/cycle unchained; a chained command directly following an issue costs 1 bubble.
- fifo_count wraps never; pointers wrap modulo DEPTH.

Optional Feature:
ALU_ISSUE_COUNT_EN
- Defined: adds output issue_count[7:0], reset 0, incremented on every edge where alu_issue is asserted. Wraps 255->0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then single push a=5,b=3,op=000 -> alu_issue high exactly one cycle after the push edge, alu_a=5, alu_b=3, alu_op=000, then busy=0.
- Push 4 back-to-back unchained commands (DEPTH=4) while issuing -> alu_issue high 4 consecutive cycles in push order, with no loss or duplicates.
- Fill FIFO with issue stalled by an all-chain backlog -> cmd_ready=0 at fifo_count=4, and a 5th cmd_valid is not accepted.
- With alu_seq attached, push a=4,b=3,op=000 then chain b=1,op=000 back-to-back -> one bubble cycle, then second issue alu_a=7, alu_b=1; next result 8.
- Assert rst while 3 commands are queued and CHAIN_WAIT is active -> next cycle fifo_count=0, alu_*=0, alu_issue=0, state IDLE, no issue afterward.
- With ALU_ISSUE_COUNT_EN defined, issue 257 commands -> issue_count=1.
